// File: rtl/wb_ram_arb_pkg.sv
// ============================================================================
// Module      : wb_ram_arb_pkg
// Description : Shared types and constants for the two-master Wishbone RAM
//               arbiter (state encoding, master index type).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_ram_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        TURN = 2'd3
    } state_e;

    typedef logic [0:0] midx_t;

endpackage

`default_nettype wire

// File: rtl/wb_ram_arb_pick.sv
// ============================================================================
// Module      : wb_ram_arb_pick
// Description : Combinational winner select for the arbiter. Round-robin when
//               WB_RAM_ARB_RR_EN is defined, else fixed priority to master 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_ram_arb_pick
    import wb_ram_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  midx_t                  last_i,
    output midx_t                  win_o
);

`ifdef WB_RAM_ARB_RR_EN
    // On a tie the master that did not win last time goes first.
    always_comb begin
        if (req_i[0] && req_i[1]) begin
            win_o = ~last_i;
        end else begin
            win_o = req_i[1] ? 1'b1 : 1'b0;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = last_i[0];

    always_comb begin
        win_o = req_i[1] ? 1'b1 : 1'b0;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/wb_ram_arb.sv
// ============================================================================
// Module      : wb_ram_arb
// Description : Two-master Wishbone classic arbiter for one byte-enabled RAM
//               slave, with turnaround cycle and ack timeout. Optional
//               round-robin tie-break via the WB_RAM_ARB_RR_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_ram_arb
    import wb_ram_arb_pkg::*;
#(
    parameter int AW      = 7,
    parameter int TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_be_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [31:0]   m0_dat_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_be_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [31:0]   m1_dat_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_be_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic          s_ack_i,
    input  logic [31:0]   s_dat_i
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] w_req;
    midx_t                  w_win, w_last;
    logic                   w_gnt0, w_gnt1, w_in_gnt, w_own_req, w_hit, w_err;

    assign w_req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign w_gnt0    = (state_q == GNT0);
    assign w_gnt1    = (state_q == GNT1);
    assign w_in_gnt  = w_gnt0 | w_gnt1;
    assign w_own_req = w_gnt1 ? w_req[1] : w_req[0];
    assign w_hit     = (TIMEOUT != 0) && w_in_gnt && (cnt_q == CW'(TIMEOUT));
    // A same-cycle ack completes the transfer normally, so it suppresses err.
    assign w_err     = w_hit & ~s_ack_i;

`ifdef WB_RAM_ARB_RR_EN
    midx_t last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && (|w_req)) begin
            last_q <= w_win;
        end
    end

    assign w_last = last_q;
`else
    assign w_last = 1'b1;
`endif

    wb_ram_arb_pick u_pick (
        .req_i  (w_req),
        .last_i (w_last),
        .win_o  (w_win)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (|w_req) state_d = (w_win == 1'b1) ? GNT1 : GNT0;
            GNT0, GNT1: if (s_ack_i || !w_own_req || w_hit) state_d = TURN;
            TURN:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Counter is held at zero outside a grant, which clears it on grant entry.
    always_comb begin
        cnt_d = '0;
        if (w_in_gnt) begin
            cnt_d = cnt_q;
            if (s_stb_o && !s_ack_i && cnt_q != {CW{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_be_o   = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (w_gnt0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = w_req[0] & ~w_hit;
            s_we_o   = m0_we_i;
            s_be_o   = m0_be_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = w_err;
            m0_dat_o = s_dat_i;
        end
        if (w_gnt1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = w_req[1] & ~w_hit;
            s_we_o   = m1_we_i;
            s_be_o   = m1_be_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = w_err;
            m1_dat_o = s_dat_i;
        end
    end

endmodule

`default_nettype wire
